// File: rtl/cont_bcd_multi.sv
// rtl/cont_bcd_multi.sv - multi-digit BCD up/down counter with prescaler and 7-segment decode
// Optional leading-zero blanking of the segment outputs: define CONT_BCD_ZERO_BLANK_EN.
module cont_bcd_multi #(
  parameter int DIGITS         = 2,
  parameter int DIV_COUNT      = 50000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(DIV_COUNT - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;

  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] loaded;
  logic                carry;
  logic                terminal;
  logic [6:0]          pat;
`ifdef CONT_BCD_ZERO_BLANK_EN
  logic                all_zero;
`endif

  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    case (d)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      default: seg_hi = 7'h00;
    endcase
  endfunction

  // Ripple carry/borrow: a digit only moves while every lower digit rolled over.
  always_comb begin
    stepped = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_down) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    loaded = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > 4'd9) loaded[4*i +: 4] = 4'd9;
    end
  end

  always_comb begin
    terminal = enable && (presc_q == PRE_TERM);
    presc_d  = presc_q;
    bcd_d    = bcd_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      presc_d = '0;
      bcd_d   = loaded;
    end else if (terminal) begin
      presc_d = '0;
      bcd_d   = stepped;
      tick_d  = 1'b1;
      wrap_d  = carry;
    end else if (enable) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      bcd_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // Walk from the top digit down so blanking knows whether everything above is zero.
  always_comb begin
    seg = '0;
    pat = '0;
`ifdef CONT_BCD_ZERO_BLANK_EN
    all_zero = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      pat = seg_hi(bcd_q[4*i +: 4]);
`ifdef CONT_BCD_ZERO_BLANK_EN
      all_zero = all_zero && (bcd_q[4*i +: 4] == 4'd0);
      if (i >= 1 && all_zero) pat = 7'h00;
`endif
      seg[7*i +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  assign bcd  = bcd_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_cont_bcd_multi.sv
// tb/tb_cont_bcd_multi.sv - randomized self-checking bench for cont_bcd_multi
// Blanking expectations follow CONT_BCD_ZERO_BLANK_EN when defined.
module tb_cont_bcd_multi;

  localparam int DIGITS    = 2;
  localparam int DIV_COUNT = 4;
  localparam bit SEG_AL    = 1'b1;
  localparam int MOD       = 100;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                up_down = 1'b1;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] load_value = '0;
  logic [4*DIGITS-1:0] bcd;
  logic [7*DIGITS-1:0] seg;
  logic                tick;
  logic                wrap;

  int n_vec = 0;
  int n_err = 0;

  int m_val, m_pre;
  bit m_tick, m_wrap;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  cont_bcd_multi #(.DIGITS(DIGITS), .DIV_COUNT(DIV_COUNT), .SEG_ACTIVE_LOW(SEG_AL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .bcd(bcd), .seg(seg),
    .tick(tick), .wrap(wrap)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] exp_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input int v);
    logic [7*DIGITS-1:0] r;
    logic [6:0] pat;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      pat = seg_tab[(v / p) % 10];
`ifdef CONT_BCD_ZERO_BLANK_EN
      if (i >= 1 && v < p) pat = 7'h00;
`endif
      r[7*i +: 7] = SEG_AL ? ~pat : pat;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit en, input bit ud, input bit ld, input logic [4*DIGITS-1:0] lv);
    int d, p;
    m_tick = 0;
    m_wrap = 0;
    if (ld) begin
      m_pre = 0;
      m_val = 0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) d = 9;
        m_val += d * p;
        p = p * 10;
      end
    end else if (en) begin
      if (m_pre == DIV_COUNT - 1) begin
        m_pre = 0;
        m_tick = 1;
        if (ud) begin
          m_wrap = (m_val == MOD - 1);
          m_val = (m_val + 1) % MOD;
        end else begin
          m_wrap = (m_val == 0);
          m_val = (m_val + MOD - 1) % MOD;
        end
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".bcd"}, 32'(bcd), 32'(exp_bcd(m_val)));
    check_eq({tag, ".tick"}, 32'(tick), 32'(m_tick));
    check_eq({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    check_eq({tag, ".seg"}, 32'(seg), 32'(exp_seg(m_val)));
  endtask

  // Called at a negedge: drive, let one posedge happen, then compare at the next negedge.
  task automatic cycle(input string tag, input bit en, input bit ud, input bit ld, input logic [4*DIGITS-1:0] lv);
    enable = en; up_down = ud; load = ld; load_value = lv;
    @(posedge clock);
    model_step(en, ud, ld, lv);
    @(negedge clock);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    check_eq("reset.seg0", 32'(seg[6:0]), 32'(7'b1000000));
    reset = 1'b0;

    for (int c = 0; c < 40; c++) cycle("up40", 1, 1, 0, '0);
    check_eq("up40.final", 32'(bcd), 32'h10);

    cycle("ld98", 1, 1, 1, 8'h98);
    for (int c = 0; c < 12; c++) cycle("wrap_up", 1, 1, 0, '0);

    cycle("ld00", 1, 0, 1, 8'h00);
    for (int c = 0; c < 8; c++) cycle("wrap_dn", 1, 0, 0, '0);

    cycle("ldAF", 1, 1, 1, 8'hAF);
    check_eq("load_sat", 32'(bcd), 32'h99);
    for (int c = 0; c < 3; c++) cycle("pre_tc", 1, 1, 0, '0);
    cycle("ld_on_tc", 1, 1, 1, 8'h05);
    for (int c = 0; c < 5; c++) cycle("after_ld", 1, 1, 0, '0);

    for (int c = 0; c < 10; c++) cycle("frozen", 0, 1, 0, '0);
    for (int c = 0; c < 6; c++) cycle("resume", 1, 1, 0, '0);

    cycle("ld10", 1, 1, 1, 8'h10);
    cycle("ld09", 0, 1, 1, 8'h09);

    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clock);
    reset = 1'b0;

    for (int c = 0; c < 400; c++) begin
      cycle("rand", ($urandom % 8) != 0, ($urandom % 4) != 0,
            ($urandom % 16) == 0, (4*DIGITS)'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cont_bcd_multi.md
Name: cont_bcd_multi

Overview:
- Parametrised multi-digit BCD up/down counter with built-in prescaler and per-digit 7-segment decode.
- Successor to the single-digit auto counter plus divider plus decoder chain.
- Runs entirely on the board clock and uses a clock-enable tick instead of a derived slow clock.
- Drives HEX displays directly; the top level instantiates it once per display group.

Parameters:
- DIGITS, 2, number of BCD digits, 1..8.
- DIV_COUNT, 50000000, prescaler period in clock cycles per count step, >=1.
- SEG_ACTIVE_LOW, 1, 1 = segment on when bit is 0 (DE-board HEX), 0 = active-high.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = prescaler runs and counting allowed; 0 = freeze prescaler and value.
- up_down  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- load  in  1  synchronous load strobe.
- load_value  in  4*DIGITS  BCD value to load, digit 0 in bits [3:0].
- bcd  out  4*DIGITS  current count, registered, digit 0 = least significant.
- seg  out  7*DIGITS  segments; digit n in bits [7n+6:7n], bit order a..g = bit0..bit6.
- tick  out  1  one-cycle pulse on each prescaler terminal count.
- wrap  out  1  one-cycle pulse when the count wraps.

Behaviour:
- Reset (async, active-high):
  - bcd=0, prescaler=0, tick=0, wrap=0.
  - seg shows "0" on every digit: 7'b1000000 when active-low, 7'b0111111 when active-high.
- Prescaler:
  - Counts 0..DIV_COUNT-1 while enable=1 and holds while enable=0.
  - On the cycle it equals DIV_COUNT-1 with enable=1, it returns to 0 and tick is registered 1 for exactly one cycle.
  - DIV_COUNT=1 gives tick every enabled cycle.
  - Width is clog2(DIV_COUNT), minimum 1.
- Count step: on the cycle tick is asserted, bcd updates. Latency is 1 cycle from prescaler terminal count to new bcd, aligned with the tick pulse.
- Up counting:
  - Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 -> all 0, and wrap=1 for that one cycle.
- Down counting:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, and wrap=1.
- Load:
  - load=1 sets bcd to load_value on the next edge, clears the prescaler to 0 and suppresses that cycle's tick and wrap.
  - load has priority over a simultaneous tick.
  - load works regardless of enable.
- Load sanitising: any loaded digit >9 is stored as 9. The counter never holds a non-BCD digit.
- up_down change: takes effect on the next tick. No partial-step behaviour.
- enable deassert: prescaler and bcd freeze. Re-assert resumes from the held prescaler value (no restart).
- Reset mid-count: all state returns to reset values immediately, independent of clock.
- seg decode:
  - Combinational from registered bcd, so zero added latency.
  - Pattern per digit: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (active-high hex, a=bit0).
  - Inverted when SEG_ACTIVE_LOW=1.

Optional Feature:
- Macro: CONT_BCD_ZERO_BLANK_EN
- With the macro defined:
  - Leading-zero blanking: digit n (n>=1) is blanked when it and every higher digit are 0.
  - Blank is all segments off: 7'h7F active-low, 7'h00 active-high.
  - Digit 0 is never blanked. Reset shows "0" on digit 0 only.
- Without the macro: every digit always decoded; bcd, tick and wrap are identical in both builds.

Test Plan (DIGITS=2, DIV_COUNT=4, SEG_ACTIVE_LOW=1):
- Reset then enable=1, up_down=1 for 40 cycles -> tick every 4th cycle, bcd 00,01,...,10 after 10 ticks; seg digit0 = 7'b1000000 at reset.
- load=1, load_value=8'h98 then up counting -> bcd 98, 99, 00 with wrap=1 exactly on the 99->00 tick.
- load_value=8'h00, up_down=0 -> next tick bcd=99, wrap=1; following tick bcd=98, wrap=0.
- load_value=8'hAF -> bcd=8'h99; load asserted on a terminal-count cycle -> no tick, prescaler restarts at 0, next tick 4 cycles later.
- enable=0 for 10 cycles mid-period -> bcd and tick frozen; re-enable resumes with the remaining prescaler count; reset asserted asynchronously between edges -> bcd=00 immediately.
- CONT_BCD_ZERO_BLANK_EN defined, bcd=05 -> seg[13:7]=7'h7F, seg[6:0]=7'b0010010; bcd=10 -> both digits lit.
